// File: rtl/sdp_y_cvt_pkg.sv
// Shared definitions for the SDP Y-path converter output buffering.
// Holds the default payload/counter widths and the FIFO occupancy constants.
package sdp_y_cvt_pkg;

    // Default payload width of one chn_out beat
    localparam int DEF_W = 16;

    // Default width of the accepted-beat counter
    localparam int DEF_CNT_W = 32;

    // Occupancy values of the 2-entry FIFO
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] FULL  = 2'd2;

endpackage : sdp_y_cvt_pkg

// File: rtl/sdp_y_cvt_fifo2.sv
// Generic 2-entry register FIFO.
// Valid, head data and occupancy all come straight from flops. The head
// register is preloaded with whatever will sit at the read pointer after
// this cycle's operations, so the read side never sees a mux path.
// A push into a full FIFO or a pop from an empty FIFO is ignored.
module sdp_y_cvt_fifo2
    import sdp_y_cvt_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic         i_clk,
    input  logic         i_rstN,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data,
    output logic         o_vld,
    output logic [1:0]   o_occ
);

    logic [W-1:0] r_mem [2];
    logic         r_wrPtr;
    logic         r_rdPtr;
    logic [1:0]   r_occ;
    logic         r_vld;
    logic [W-1:0] r_dout;

    logic         w_doPush;
    logic         w_doPop;
    logic         w_rdPtrNext;
    logic [1:0]   w_occNext;
    logic [W-1:0] w_headNext;

    // Qualify the requests and work out the next occupancy and next head value
    always_comb begin
        w_doPush    = i_push && (r_occ != FULL);
        w_doPop     = i_pop && (r_occ != EMPTY);
        w_rdPtrNext = r_rdPtr ^ w_doPop;
        w_occNext   = r_occ + {1'b0, w_doPush} - {1'b0, w_doPop};
        w_headNext  = r_dout;
        if (w_doPush && (r_wrPtr == w_rdPtrNext)) begin
            w_headNext = i_data;
        end else if (w_occNext != EMPTY) begin
            w_headNext = r_mem[w_rdPtrNext];
        end
    end

    // Storage entries: write the incoming beat at the write pointer
    always_ff @(posedge i_clk or negedge i_rstN) begin
        if (!i_rstN) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
        end else if (w_doPush) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

    // Pointers, occupancy and the registered read-side outputs
    always_ff @(posedge i_clk or negedge i_rstN) begin
        if (!i_rstN) begin
            r_wrPtr <= 1'b0;
            r_rdPtr <= 1'b0;
            r_occ   <= EMPTY;
            r_vld   <= 1'b0;
            r_dout  <= '0;
        end else begin
            r_wrPtr <= r_wrPtr ^ w_doPush;
            r_rdPtr <= w_rdPtrNext;
            r_occ   <= w_occNext;
            r_vld   <= (w_occNext != EMPTY);
            r_dout  <= w_headNext;
        end
    end

    assign o_data = r_dout;
    assign o_vld  = r_vld;
    assign o_occ  = r_occ;

endmodule : sdp_y_cvt_fifo2

// File: rtl/sdp_y_cvt_chn_out_obuf.sv
// Output buffer for the SDP Y-path converter chn_out channel.
// Accepts core writes whenever the 2-entry FIFO is not full and reports the
// accept on chn_out_rsci_biwt. The accept depends only on oswt and the
// registered occupancy, so downstream ready never reaches back into the core.
module sdp_y_cvt_chn_out_obuf
    import sdp_y_cvt_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rstn,
    input  logic             chn_out_rsci_oswt,
    input  logic [W-1:0]     chn_out_rsci_d,
    output logic             chn_out_rsci_biwt,
    output logic             chn_out_vld,
    input  logic             chn_out_rdy,
    output logic [W-1:0]     chn_out_pd,
    output logic [1:0]       chn_out_occ,
    output logic             chn_out_idle,
    output logic [CNT_W-1:0] chn_out_beat_cnt
);

    logic             w_push;
    logic             w_pop;
    logic             w_vld;
    logic [1:0]       w_occ;
    logic [W-1:0]     w_pd;
    logic [CNT_W-1:0] r_beatCnt;

    // Accept a core write unless the FIFO is already full; idle when empty and no request
    always_comb begin
        w_push       = chn_out_rsci_oswt && (w_occ != FULL);
        w_pop        = w_vld && chn_out_rdy;
        chn_out_idle = (w_occ == EMPTY) && !chn_out_rsci_oswt;
    end

    sdp_y_cvt_fifo2 #(
        .W (W)
    ) u_fifo (
        .i_clk  (nvdla_core_clk),
        .i_rstN (nvdla_core_rstn),
        .i_push (w_push),
        .i_pop  (w_pop),
        .i_data (chn_out_rsci_d),
        .o_data (w_pd),
        .o_vld  (w_vld),
        .o_occ  (w_occ)
    );

    // Count every beat accepted from the core, wrapping freely
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_beatCnt <= '0;
        end else if (w_push) begin
            r_beatCnt <= r_beatCnt + CNT_W'(1);
        end
    end

    assign chn_out_rsci_biwt = w_push;
    assign chn_out_vld       = w_vld;
    assign chn_out_pd        = w_pd;
    assign chn_out_occ       = w_occ;
    assign chn_out_beat_cnt  = r_beatCnt;

endmodule : sdp_y_cvt_chn_out_obuf
